set_stream_buffer: RTL and testbench

Parametrised set-granular stream buffer between the input-side loaders and the convolution array. Each cycle it accepts a variable number (0..IN_NUM_OF_SET) of DATA_OF_SET-element sets and presents up to OUT_NUM_OF_SET sets in first-word-fall-through order. The consumer pops the presented sets with a handshake. Adds variable input count, consumer pop, occupancy reporting, flush and an optional overflow flag over the first-generation buffer.

---
 rtl/set_stream_buffer_if.sv | 32 +++
 rtl/set_stream_buffer.sv | 112 +++++++++++
 tb/tb_set_stream_buffer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/set_stream_buffer_if.sv
// Handshake/data bundle between the loaders, the set stream buffer and the conv-array consumer.
// The buffer connects through the slave modport and the producer/consumer side through master.
interface set_stream_buffer_if #(
   parameter int unsigned DATA_WIDTH     = 4,
   parameter int unsigned DATA_OF_SET    = 4,
   parameter int unsigned IN_NUM_OF_SET  = 4,
   parameter int unsigned OUT_NUM_OF_SET = 2,
   parameter int unsigned BUFFER_SIZE    = 8
);
   localparam int unsigned DIN_CNT_W = $clog2(IN_NUM_OF_SET + 1);
   localparam int unsigned CNT_W     = $clog2(BUFFER_SIZE + 1);

   logic                                                   flush;
   logic                                                   wen;
   logic [DIN_CNT_W-1:0]                                   din_cnt;
   logic [IN_NUM_OF_SET-1:0][DATA_OF_SET-1:0][DATA_WIDTH-1:0]  din;
   logic                                                   full_flag;
   logic                                                   ren;
   logic [OUT_NUM_OF_SET-1:0][DATA_OF_SET-1:0][DATA_WIDTH-1:0] dout;
   logic [OUT_NUM_OF_SET-1:0]                              valid;
   logic [CNT_W-1:0]                                       count;

   modport master (
      output flush, wen, din_cnt, din, ren,
      input  full_flag, dout, valid, count
   );

   modport slave (
      input  flush, wen, din_cnt, din, ren,
      output full_flag, dout, valid, count
   );
endinterface

// File: rtl/set_stream_buffer.sv
// Set-granular circular stream buffer: variable-count writes, FWFT multi-lane reads with pop.
// Optional sticky overflow flag port ovf_err is enabled by defining SET_BUFFER_OVF_ERR_EN.
module set_stream_buffer #(
   parameter int unsigned DATA_WIDTH     = 4,
   parameter int unsigned DATA_OF_SET    = 4,
   parameter int unsigned IN_NUM_OF_SET  = 4,
   parameter int unsigned OUT_NUM_OF_SET = 2,
   parameter int unsigned BUFFER_SIZE    = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   set_stream_buffer_if.slave    bus
`ifdef SET_BUFFER_OVF_ERR_EN
   ,
   output logic                  ovf_err
`endif
);
   localparam int unsigned DIN_CNT_W = $clog2(IN_NUM_OF_SET + 1);
   localparam int unsigned CNT_W     = $clog2(BUFFER_SIZE + 1);
   localparam int unsigned PTR_W     = $clog2(BUFFER_SIZE);

   typedef logic [DATA_OF_SET-1:0][DATA_WIDTH-1:0] set_t;

   set_t                 mem_q [BUFFER_SIZE];
   logic [PTR_W-1:0]     wp_q, wp_d;
   logic [PTR_W-1:0]     rp_q, rp_d;
   logic [CNT_W-1:0]     count_q, count_d;

   logic                 full_c;
   logic                 wr_acc_c;
   logic [DIN_CNT_W-1:0] cnt_eff_c;
   logic [DIN_CNT_W-1:0] wr_cnt_c;
   logic [CNT_W-1:0]     pop_cnt_c;

   // Occupancy-derived status and the clamped write/pop amounts for this cycle
   always_comb begin
      full_c    = (CNT_W'(BUFFER_SIZE) - count_q) < CNT_W'(IN_NUM_OF_SET);
      cnt_eff_c = (bus.din_cnt > DIN_CNT_W'(IN_NUM_OF_SET)) ? DIN_CNT_W'(IN_NUM_OF_SET)
                                                            : bus.din_cnt;
      wr_acc_c  = bus.wen && !full_c && !bus.flush;
      wr_cnt_c  = wr_acc_c ? cnt_eff_c : '0;
      pop_cnt_c = '0;
      if (bus.ren && !bus.flush) begin
         pop_cnt_c = (count_q >= CNT_W'(OUT_NUM_OF_SET)) ? CNT_W'(OUT_NUM_OF_SET) : count_q;
      end
   end

   // Next pointer/occupancy state; flush overrides any write or pop
   always_comb begin
      wp_d    = wp_q + PTR_W'(wr_cnt_c);
      rp_d    = rp_q + PTR_W'(pop_cnt_c);
      count_d = count_q + CNT_W'(wr_cnt_c) - pop_cnt_c;
      if (bus.flush) begin
         wp_d    = '0;
         rp_d    = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wp_q    <= '0;
         rp_q    <= '0;
         count_q <= '0;
      end else begin
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         count_q <= count_d;
      end
   end

   // Storage is deliberately left unreset; validity comes from count
   always_ff @(posedge clk) begin
      for (int i = 0; i < int'(IN_NUM_OF_SET); i++) begin
         if (wr_acc_c && (DIN_CNT_W'(i) < cnt_eff_c)) begin
            mem_q[wp_q + PTR_W'(i)] <= bus.din[i];
         end
      end
   end

   // FWFT lanes: lane k shows the k-th oldest set, zeroed when not valid
   always_comb begin
      bus.full_flag = full_c;
      bus.count     = count_q;
      for (int k = 0; k < int'(OUT_NUM_OF_SET); k++) begin
         bus.valid[k] = count_q > CNT_W'(k);
         bus.dout[k]  = bus.valid[k] ? mem_q[rp_q + PTR_W'(k)] : '0;
      end
   end

`ifdef SET_BUFFER_OVF_ERR_EN
   logic ovf_q, ovf_d;

   always_comb begin
      ovf_d = ovf_q | (bus.wen && (bus.din_cnt != '0) && full_c);
      if (bus.flush) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign ovf_err = ovf_q;
`endif

endmodule

// File: tb/tb_set_stream_buffer.sv
// Scoreboard bench for set_stream_buffer: directed plan plus random traffic against a set-queue model.
module tb_set_stream_buffer;
   localparam int unsigned DW  = 4;
   localparam int unsigned DOS = 4;
   localparam int unsigned IN  = 4;
   localparam int unsigned OUT = 2;
   localparam int unsigned BUF = 8;
   localparam int unsigned DCW = $clog2(IN + 1);

   typedef logic [DOS-1:0][DW-1:0]          set_t;
   typedef logic [IN-1:0][DOS-1:0][DW-1:0]  din_t;
   typedef logic [OUT-1:0][DOS-1:0][DW-1:0] dout_t;

   typedef struct {
      logic [OUT-1:0] valid;
      dout_t          dout;
      int             count;
      logic           full;
      logic           ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;

   set_stream_buffer_if #(.DATA_WIDTH(DW), .DATA_OF_SET(DOS), .IN_NUM_OF_SET(IN),
                          .OUT_NUM_OF_SET(OUT), .BUFFER_SIZE(BUF)) bus ();

`ifdef SET_BUFFER_OVF_ERR_EN
   logic ovf_err;
`endif

   set_stream_buffer #(.DATA_WIDTH(DW), .DATA_OF_SET(DOS), .IN_NUM_OF_SET(IN),
                       .OUT_NUM_OF_SET(OUT), .BUFFER_SIZE(BUF)) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus)
`ifdef SET_BUFFER_OVF_ERR_EN
      ,
      .ovf_err (ovf_err)
`endif
   );

   always #5 clk = ~clk;

   int   total = 0;
   int   bad   = 0;
   exp_t exp_q [$];
   set_t mq [$];
   logic m_ovf = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s at %0t: got=%0h expected=%0h", nm, $time, act, req);
      end
   endtask

   function automatic din_t fill(input int v0, input int v1, input int v2, input int v3);
      din_t d;
      for (int e = 0; e < int'(DOS); e++) begin
         d[0][e] = DW'(v0);
         d[1][e] = DW'(v1);
         d[2][e] = DW'(v2);
         d[3][e] = DW'(v3);
      end
      return d;
   endfunction

   function automatic exp_t snapshot();
      exp_t e;
      e.dout = '0;
      for (int k = 0; k < int'(OUT); k++) begin
         e.valid[k] = (k < mq.size());
         if (k < mq.size()) e.dout[k] = mq[k];
      end
      e.count = mq.size();
      e.full  = (int'(BUF) - mq.size()) < int'(IN);
      e.ovf   = m_ovf;
      return e;
   endfunction

   // Apply inputs for one clock, then update the queue model with what that edge should do
   task automatic cycle(input logic w, input logic [DCW-1:0] c, input din_t d,
                        input logic r, input logic f);
      int n;
      int p;
      bit full;
      bus.wen = w; bus.din_cnt = c; bus.din = d; bus.ren = r; bus.flush = f;
      @(posedge clk);
      #1;
      n    = (int'(c) > int'(IN)) ? int'(IN) : int'(c);
      full = (int'(BUF) - mq.size()) < int'(IN);
      if (f) begin
         mq.delete();
         m_ovf = 1'b0;
      end else begin
         p = r ? ((mq.size() < int'(OUT)) ? mq.size() : int'(OUT)) : 0;
         repeat (p) void'(mq.pop_front());
         if (w && n != 0 && full) m_ovf = 1'b1;
         if (w && !full) for (int i = 0; i < n; i++) mq.push_back(d[i]);
      end
      exp_q.push_back(snapshot());
   endtask

   task automatic idle_inputs();
      bus.wen = 1'b0; bus.din_cnt = '0; bus.din = '0; bus.ren = 1'b0; bus.flush = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_valid"}, 64'(bus.valid), 64'd0);
      chk({tag, "_count"}, 64'(bus.count), 64'd0);
      chk({tag, "_full"},  64'(bus.full_flag), 64'd0);
      chk({tag, "_dout"},  64'(bus.dout), 64'd0);
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must clear before the next edge
   task automatic async_reset(input int cycles);
      exp_q.delete();
      idle_inputs();
      rst = 1'b0;
      #1;
      check_zero("rst_async");
      mq.delete();
      m_ovf = 1'b0;
      repeat (cycles) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check_zero("rst_release");
   endtask

   // Monitor: compare every cycle the DUT presents against the oldest queued expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("valid", 64'(bus.valid), 64'(e.valid));
            chk("dout",  64'(bus.dout),  64'(e.dout));
            chk("count", 64'(bus.count), 64'(e.count));
            chk("full",  64'(bus.full_flag), 64'(e.full));
`ifdef SET_BUFFER_OVF_ERR_EN
            chk("ovf_err", 64'(ovf_err), 64'(e.ovf));
`endif
         end
      end
   end

   initial begin
      din_t rd;
      idle_inputs();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check_zero("rst_init");

      // Basic write, fill, dropped overflow write
      cycle(1, 4, fill(1, 1, 1, 1), 0, 0);
      cycle(1, 4, fill(2, 2, 2, 2), 0, 0);
      cycle(1, 4, fill(3, 3, 3, 3), 0, 0);
      cycle(0, 0, '0, 0, 0);
      // Drain in order, then a partial write of three sets
      repeat (4) cycle(0, 0, '0, 1, 0);
      cycle(0, 0, '0, 1, 0);
      cycle(1, 3, fill(5, 6, 7, 0), 0, 0);
      cycle(0, 0, '0, 1, 0);
      cycle(0, 0, '0, 1, 0);
      // Move pointers to slot 6, then concurrent write+pop across the wrap
      cycle(1, 3, fill(8, 8, 8, 0), 0, 0);
      cycle(0, 0, '0, 1, 0);
      cycle(0, 0, '0, 1, 0);
      cycle(1, 4, fill(10, 11, 12, 13), 0, 0);
      cycle(1, 4, fill(4, 4, 4, 4), 1, 0);
      cycle(1, 7, fill(14, 14, 14, 14), 0, 0);
      cycle(0, 0, '0, 1, 0);
      // Flush beats simultaneous write and pop
      cycle(1, 4, fill(9, 9, 9, 9), 1, 1);
      cycle(0, 0, '0, 1, 0);
      // Reset while holding four sets
      cycle(1, 4, fill(6, 6, 6, 6), 0, 0);
      async_reset(1);
      cycle(1, 2, fill(12, 13, 0, 0), 0, 0);
      cycle(0, 0, '0, 0, 0);

      // Random traffic
      for (int t = 0; t < 2000; t++) begin
         if ($urandom_range(0, 399) == 0) begin
            async_reset($urandom_range(1, 2));
         end else begin
            rd = din_t'({$urandom(), $urandom()});
            cycle(($urandom_range(0, 3) != 0), DCW'($urandom_range(0, 7)), rd,
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 49) == 0));
         end
      end

      idle_inputs();
      for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
      #1;
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
